// File: rtl/pio_cond_pkg.sv
// pio_cond_pkg: counter sizing helpers and filter-decision encoding for the PIO input conditioner
package pio_cond_pkg;

    typedef enum logic [1:0] {
        EQ          = 2'd0,
        DIFF_COUNT  = 2'd1,
        DIFF_ACCEPT = 2'd2
    } filt_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int cnt_w(input int cycles);
        return (clog2(cycles + 1) < 1) ? 1 : clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// pio_debounce_bit: one input bit = synchroniser, debounce counter, level register, edge strobes
module pio_debounce_bit
    import pio_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_W = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync_q;
    filt_e                  w_cmp;

    assign w_sync_q = r_sync[SYNC_STAGES-1];
    assign w_cmp    = (w_sync_q == r_level) ? EQ : (r_cnt == TERM) ? DIFF_ACCEPT : DIFF_COUNT;

    // synchronise the pin; accept a new level only after TERM+1 consecutive differing samples,
    // any reversion restarts the count so the counter never exceeds TERM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= {SYNC_STAGES{RESET_LEVEL}};
            r_cnt   <= '0;
            r_level <= RESET_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_cnt   <= (w_cmp == DIFF_COUNT) ? r_cnt + 1'b1 : '0;
            r_level <= (w_cmp == DIFF_ACCEPT) ? w_sync_q : r_level;
            r_rise  <= (w_cmp == DIFF_ACCEPT) && w_sync_q;
            r_fall  <= (w_cmp == DIFF_ACCEPT) && !w_sync_q;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/pio_input_conditioner.sv
// pio_input_conditioner: per-bit sync + debounce of raw pins with rise/fall strobes;
// optional sticky edge capture enabled by PIO_INPUT_CONDITIONER_EDGE_CAPTURE_EN
module pio_input_conditioner
    import pio_cond_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_in,
    input  logic [WIDTH-1:0] clr_edges,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] edge_capture
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .i_async (async_in[i]),
            .o_level (data_out[i]),
            .o_rise  (rise_pulse[i]),
            .o_fall  (fall_pulse[i])
        );
    end

`ifdef PIO_INPUT_CONDITIONER_EDGE_CAPTURE_EN
    logic [WIDTH-1:0] r_cap;

    // sticky edge flags; a set in the same cycle as a clear wins so no event is lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_cap <= '0;
        else r_cap <= (r_cap & ~clr_edges) | rise_pulse | fall_pulse;
    end

    assign edge_capture = r_cap;
`else
    logic w_unused_clr;

    assign w_unused_clr = ^clr_edges;
    assign edge_capture = '0;
`endif

endmodule
